// File: rtl/keypad_db_pkg.sv
// Shared defaults and elaboration helpers for the keypad debouncer.
package keypad_db_pkg;

  localparam int unsigned DB_TICK_DIV_DEFAULT   = 250000;
  localparam int unsigned DB_STABLE_CNT_DEFAULT = 4;

  // Bits needed to encode values 0..value-1.
  function automatic int unsigned db_clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned p = 1; p < value; p = p << 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/keypad_db_channel.sv
// One debounced key: 2-flop synchronizer, polarity fix, tick-qualified stability counter.
// Edge pulses exist only when KEYPAD_DB_EDGE_EN is defined; otherwise they are tied low.
module keypad_db_channel
  import keypad_db_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DB_STABLE_CNT_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned   CW       = db_clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          sample;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  assign sample = sync_q2 ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (tick) begin
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sample;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef KEYPAD_DB_EDGE_EN
  logic accept;

  // Same condition that updates level, so pulses line up with the level change.
  assign accept = tick && (sample != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept & sample;
      fall <= accept & ~sample;
    end
  end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif

endmodule

// File: rtl/keypad_debounce_n.sv
// Multi-channel keypad debouncer: shared sample-tick divider plus one channel per key.
// Optional edge pulses controlled by macro KEYPAD_DB_EDGE_EN.
module keypad_debounce_n
  import keypad_db_pkg::*;
#(
  parameter int unsigned FREQ_HZ    = 50000000,
  parameter int unsigned TICK_DIV   = DB_TICK_DIV_DEFAULT,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned STABLE_CNT = DB_STABLE_CNT_DEFAULT,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                CLK_DB,
  input  logic                RST_DB,
  input  logic [CHANNELS-1:0] Presion_Boton,
  output logic [CHANNELS-1:0] PB_D,
  output logic [CHANNELS-1:0] PB_RISE,
  output logic [CHANNELS-1:0] PB_FALL,
  output logic                ANY_PRESSED
);

  localparam int unsigned   TW        = db_clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  if (FREQ_HZ == 0 || TICK_DIV < 2 || CHANNELS < 1 || CHANNELS > 32 || STABLE_CNT < 1) begin : g_bad_cfg
    $error("keypad_debounce_n: illegal parameter set");
  end

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge CLK_DB) begin
    if (RST_DB) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    keypad_db_channel #(
      .STABLE_CNT (STABLE_CNT),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk   (CLK_DB),
      .rst   (RST_DB),
      .tick  (tick),
      .raw   (Presion_Boton[i]),
      .level (PB_D[i]),
      .rise  (PB_RISE[i]),
      .fall  (PB_FALL[i])
    );
  end

  assign ANY_PRESSED = |PB_D;

endmodule

// File: tb/tb_keypad_debounce_n.sv
// Directed bench for keypad_debounce_n; pulse expectations follow KEYPAD_DB_EDGE_EN.
module tb_keypad_debounce_n;

`ifdef KEYPAD_DB_EDGE_EN
  localparam int unsigned EDGE_EXP = 1;
`else
  localparam int unsigned EDGE_EXP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = '0;
  logic [3:0] pb_d, pb_rise, pb_fall;
  logic       any;
  logic [0:0] raw_al = 1'b1;
  logic [0:0] al_d, al_rise, al_fall;
  logic       al_any;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  keypad_debounce_n #(
    .FREQ_HZ    (100),
    .TICK_DIV   (10),
    .CHANNELS   (4),
    .STABLE_CNT (4),
    .ACTIVE_LOW (1'b0)
  ) dut (
    .CLK_DB        (clk),
    .RST_DB        (rst),
    .Presion_Boton (raw),
    .PB_D          (pb_d),
    .PB_RISE       (pb_rise),
    .PB_FALL       (pb_fall),
    .ANY_PRESSED   (any)
  );

  keypad_debounce_n #(
    .FREQ_HZ    (100),
    .TICK_DIV   (10),
    .CHANNELS   (1),
    .STABLE_CNT (4),
    .ACTIVE_LOW (1'b1)
  ) dut_al (
    .CLK_DB        (clk),
    .RST_DB        (rst),
    .Presion_Boton (raw_al),
    .PB_D          (al_d),
    .PB_RISE       (al_rise),
    .PB_FALL       (al_fall),
    .ANY_PRESSED   (al_any)
  );

  // Pulse-cycle and level-change counters, sampled on the falling edge.
  int unsigned rise_cnt[4];
  int unsigned fall_cnt[4];
  int unsigned chg_cnt[4];
  int unsigned al_pulse_cnt = 0;
  logic [3:0]  pb_d_prev = '0;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pb_rise[i] === 1'b1) rise_cnt[i]++;
      if (pb_fall[i] === 1'b1) fall_cnt[i]++;
      if (pb_d[i] !== pb_d_prev[i]) chg_cnt[i]++;
    end
    if (al_rise[0] === 1'b1 || al_fall[0] === 1'b1) al_pulse_cnt++;
    pb_d_prev = pb_d;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic level_of(input int sel);
    if (sel == 4) return al_d[0];
    return pb_d[sel];
  endfunction

  // Counts edges until the selected level reaches val; max+1 means timeout.
  task automatic wait_level(input int sel, input logic val, input int max, output int n);
    n = 0;
    while (n < max) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (level_of(sel) === val) return;
    end
    n = max + 1;
  endtask

  int          n;
  int unsigned base_r, base_f, base_c;
  int unsigned tot_r0, tot_f0, al_p0;

  initial begin
    // Reset state
    step(3);
    rst = 1'b0;
    check_eq("rst_pb_d", 32'(pb_d), 32'h0);
    check_eq("rst_rise", 32'(pb_rise), 32'h0);
    check_eq("rst_fall", 32'(pb_fall), 32'h0);
    check_eq("rst_any", 32'(any), 32'h0);
    check_eq("rst_al_d", 32'(al_d), 32'h0);
    tot_r0 = rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3];
    tot_f0 = fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3];
    al_p0  = al_pulse_cnt;

    // Clean press on ch0
    step(5);
    base_r = rise_cnt[0];
    raw[0] = 1'b1;
    wait_level(0, 1'b1, 42, n);
    check_eq("press_latency_ok", 32'(n >= 33 && n <= 42), 32'h1);
    check_eq("press_rise_now", 32'(pb_rise[0]), EDGE_EXP);
    check_eq("press_any", 32'(any), 32'h1);
    @(posedge clk);
    @(negedge clk);
    check_eq("press_rise_after", 32'(pb_rise[0]), 32'h0);
    check_eq("press_hold", 32'(pb_d[0]), 32'h1);
    step(20);
    check_eq("press_rise_cycles", rise_cnt[0] - base_r, EDGE_EXP);

    // Bounce on ch1: 7-cycle segments for 70 cycles, then held high
    base_r = rise_cnt[1];
    base_c = chg_cnt[1];
    for (int seg = 0; seg < 10; seg++) begin
      raw[1] = (seg % 2 == 0);
      step(7);
    end
    check_eq("bounce_no_change", chg_cnt[1] - base_c, 32'h0);
    raw[1] = 1'b1;
    wait_level(1, 1'b1, 45, n);
    check_eq("bounce_settle_ok", 32'(n <= 45), 32'h1);
    step(20);
    check_eq("bounce_changes", chg_cnt[1] - base_c, 32'h1);
    check_eq("bounce_rise_cycles", rise_cnt[1] - base_r, EDGE_EXP);

    // Glitch on ch2: three ticks high, then low
    base_r = rise_cnt[2];
    base_f = fall_cnt[2];
    base_c = chg_cnt[2];
    raw[2] = 1'b1;
    step(30);
    raw[2] = 1'b0;
    step(60);
    check_eq("glitch_pb_d", 32'(pb_d[2]), 32'h0);
    check_eq("glitch_changes", chg_cnt[2] - base_c, 32'h0);
    check_eq("glitch_pulses", (rise_cnt[2] - base_r) + (fall_cnt[2] - base_f), 32'h0);

    // Simultaneous: press ch2 while releasing ch3
    raw[3] = 1'b1;
    wait_level(3, 1'b1, 45, n);
    check_eq("ch3_press_ok", 32'(n <= 45), 32'h1);
    step(5);
    raw[2] = 1'b1;
    raw[3] = 1'b0;
    wait_level(2, 1'b1, 45, n);
    check_eq("simul_ch2_ok", 32'(n >= 33 && n <= 42), 32'h1);
    check_eq("simul_ch3_released", 32'(pb_d[3]), 32'h0);
    check_eq("simul_rise2", 32'(pb_rise[2]), EDGE_EXP);
    check_eq("simul_fall3", 32'(pb_fall[3]), EDGE_EXP);
    check_eq("simul_any", 32'(any), 32'h1);

    // Reset mid-debounce on ch0 after two qualifying ticks
    @(posedge clk);
    #1;
    rst = 1'b1;
    raw = '0;
    step(1);
    rst = 1'b0;
    raw[0] = 1'b1;
    step(21);
    check_eq("pre_reset_pb_d0", 32'(pb_d[0]), 32'h0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_eq("midrst_pb_d", 32'(pb_d), 32'h0);
    check_eq("midrst_edges", 32'({pb_rise, pb_fall}), 32'h0);
    check_eq("midrst_any", 32'(any), 32'h0);
    wait_level(0, 1'b1, 50, n);
    check_eq("midrst_latency", 32'(n), 32'd40);
    check_eq("midrst_rise", 32'(pb_rise[0]), EDGE_EXP);

    // Active-low instance: held 1 reads released, driven 0 reads pressed
    step(30);
    check_eq("al_idle", 32'(al_d), 32'h0);
    check_eq("al_idle_any", 32'(al_any), 32'h0);
    raw_al = 1'b0;
    wait_level(4, 1'b1, 45, n);
    check_eq("al_press_ok", 32'(n >= 33 && n <= 42), 32'h1);
    check_eq("al_any", 32'(al_any), 32'h1);
    step(5);

    // Overall pulse totals
    check_eq("total_rise",
             (rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]) - tot_r0, 5 * EDGE_EXP);
    check_eq("total_fall",
             (fall_cnt[0] + fall_cnt[1] + fall_cnt[2] + fall_cnt[3]) - tot_f0, 1 * EDGE_EXP);
    check_eq("al_pulses", al_pulse_cnt - al_p0, EDGE_EXP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
